// File: rtl/bilstm_pkg.sv
// Shared constants and types for the BiLSTM gate datapaths.
package bilstm_pkg;

  // Q7.8 signed fixed point
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;
  localparam int ACC_WIDTH  = 40;
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = 16'sh8000;

  // Matrix geometry: two weights per packed memory word
  localparam int HIDDEN_SIZE   = 128;
  localparam int WORDS_PER_ROW = HIDDEN_SIZE / 2;
  localparam int ADDR_WIDTH    = 13;
  localparam int H_ADDR_WIDTH  = 6;
  localparam int ROW_WIDTH     = $clog2(HIDDEN_SIZE);

  // Mat-vec sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    DRAIN   = 2'd2,
    PRESENT = 2'd3
  } state_t;

endpackage

// File: rtl/hh_output_gate_matvec_if.sv
// Memory read ports and result handshake of the output-gate mat-vec unit.
//
// Handshake: out_valid/out_data/out_row are held stable by the master while
// out_valid=1 and out_ready=0; a transfer happens on every rising clk edge
// where out_valid and out_ready are both 1. Memory reads have no handshake:
// data is returned exactly one cycle after the matching read enable.
interface hh_output_gate_matvec_if #(
  parameter int DATA_WIDTH   = bilstm_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = bilstm_pkg::ADDR_WIDTH,
  parameter int H_ADDR_WIDTH = bilstm_pkg::H_ADDR_WIDTH,
  parameter int ROW_WIDTH    = bilstm_pkg::ROW_WIDTH
);
  logic                    w_rd_en;
  logic [ADDR_WIDTH-1:0]   w_rd_addr;
  logic [2*DATA_WIDTH-1:0] w_rd_data;
  logic                    h_rd_en;
  logic [H_ADDR_WIDTH-1:0] h_rd_addr;
  logic [2*DATA_WIDTH-1:0] h_rd_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [ROW_WIDTH-1:0]    out_row;
  logic [DATA_WIDTH-1:0]   out_data;

  modport master (
    output w_rd_en, w_rd_addr, input w_rd_data,
    output h_rd_en, h_rd_addr, input h_rd_data,
    output out_valid, out_row, out_data, input out_ready
  );

  modport slave (
    input w_rd_en, w_rd_addr, output w_rd_data,
    input h_rd_en, h_rd_addr, output h_rd_data,
    input out_valid, out_row, out_data, output out_ready
  );
endinterface

// File: rtl/hh_output_gate_matvec_dual_mac_sat.sv
// Two-lane signed multiply, lane sum and accumulate, with a floor-shift and
// saturate view of the accumulator in the data format.
module dual_mac_sat #(
  parameter int DATA_WIDTH = bilstm_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = bilstm_pkg::FRAC_BITS,
  parameter int ACC_WIDTH  = bilstm_pkg::ACC_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [2*DATA_WIDTH-1:0] w_word,
  input  logic [2*DATA_WIDTH-1:0] h_word,
  input  logic                    clear,
  output logic                    pipe_busy,
  output logic [DATA_WIDTH-1:0]   result
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(-(2**(DATA_WIDTH-1)));

  logic signed [DATA_WIDTH-1:0] w_lo, w_hi, h_lo, h_hi;
  logic signed [PW-1:0]         p_lo_q, p_hi_q;
  logic                         prod_valid_q;
  logic signed [PW:0]           lane_sum;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [ACC_WIDTH-1:0]  shifted;

  // Low half is the even column, high half the odd column
  assign w_lo = w_word[DATA_WIDTH-1:0];
  assign w_hi = w_word[PW-1:DATA_WIDTH];
  assign h_lo = h_word[DATA_WIDTH-1:0];
  assign h_hi = h_word[PW-1:DATA_WIDTH];

  assign lane_sum  = (PW+1)'(p_lo_q) + (PW+1)'(p_hi_q);
  assign pipe_busy = prod_valid_q;
  assign shifted   = acc_q >>> FRAC_BITS;

  // Product register stage followed by the accumulate stage
  always_ff @(posedge clk) begin
    if (rst) begin
      p_lo_q       <= '0;
      p_hi_q       <= '0;
      prod_valid_q <= 1'b0;
      acc_q        <= '0;
    end else begin
      prod_valid_q <= in_valid;
      if (in_valid) begin
        p_lo_q <= PW'(w_lo) * PW'(h_lo);
        p_hi_q <= PW'(w_hi) * PW'(h_hi);
      end
      if (clear)
        acc_q <= '0;
      else if (prod_valid_q)
        acc_q <= acc_q + ACC_WIDTH'(lane_sum);
    end
  end

  // Arithmetic shift floors toward -inf; clamp to the data range
  always_comb begin
    if (shifted > SAT_HI)
      result = SAT_HI[DATA_WIDTH-1:0];
    else if (shifted < SAT_LO)
      result = SAT_LO[DATA_WIDTH-1:0];
    else
      result = shifted[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/hh_output_gate_matvec.sv
// Output-gate W_hh * h(t-1) sequencer: streams one weight row and h(t-1)
// through the dual MAC, then presents the saturated row result downstream.
module hh_output_gate_matvec #(
  parameter int DATA_WIDTH   = bilstm_pkg::DATA_WIDTH,
  parameter int FRAC_BITS    = bilstm_pkg::FRAC_BITS,
  parameter int HIDDEN_SIZE  = bilstm_pkg::HIDDEN_SIZE,
  parameter int ADDR_WIDTH   = bilstm_pkg::ADDR_WIDTH,
  parameter int H_ADDR_WIDTH = bilstm_pkg::H_ADDR_WIDTH,
  parameter int ACC_WIDTH    = bilstm_pkg::ACC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output bilstm_pkg::state_t  dbg_state,
  hh_output_gate_matvec_if.master bus
);
  import bilstm_pkg::*;

  localparam int WPR   = HIDDEN_SIZE / 2;
  localparam int ROW_W = $clog2(HIDDEN_SIZE);
  localparam logic [H_ADDR_WIDTH-1:0] K_LAST   = H_ADDR_WIDTH'(WPR - 1);
  localparam logic [ROW_W-1:0]        ROW_LAST = ROW_W'(HIDDEN_SIZE - 1);

  state_t                  state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [H_ADDR_WIDTH-1:0] k_q, k_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [ROW_W-1:0]        out_row_q, out_row_d;
  logic                    data_valid_q;
  logic [ADDR_WIDTH-1:0]   w_hold_q, cur_w_addr;
  logic [H_ADDR_WIDTH-1:0] h_hold_q;
  logic                    issue, mac_clear, mac_busy;
  logic [DATA_WIDTH-1:0]   mac_result;

  assign issue      = (state_q == ISSUE);
  assign cur_w_addr = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(WPR) + ADDR_WIDTH'(k_q);

  // Addresses track the live counters while issuing and hold otherwise
  assign bus.w_rd_en   = issue;
  assign bus.h_rd_en   = issue;
  assign bus.w_rd_addr = issue ? cur_w_addr : w_hold_q;
  assign bus.h_rd_addr = issue ? k_q : h_hold_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = out_row_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign dbg_state     = state_q;

  dual_mac_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (data_valid_q),
    .w_word    (bus.w_rd_data),
    .h_word    (bus.h_rd_data),
    .clear     (mac_clear),
    .pipe_busy (mac_busy),
    .result    (mac_result)
  );

  // State, counters, output and pipeline-valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      k_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      data_valid_q <= 1'b0;
      w_hold_q     <= '0;
      h_hold_q     <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      k_q          <= k_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_row_q    <= out_row_d;
      data_valid_q <= issue;
      if (issue) begin
        w_hold_q <= cur_w_addr;
        h_hold_q <= k_q;
      end
    end
  end

  // Next-state and output decisions of the row sequencer
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    k_d         = k_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    mac_clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ISSUE;
          row_d     = '0;
          k_d       = '0;
          busy_d    = 1'b1;
          mac_clear = 1'b1;
        end
      end
      ISSUE: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        // Both pipeline stages empty means the last word is in the accumulator
        if (!data_valid_q && !mac_busy) begin
          out_valid_d = 1'b1;
          out_data_d  = mac_result;
          out_row_d   = row_q;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          mac_clear   = 1'b1;
          if (row_q == ROW_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            k_d     = '0;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hh_output_gate_matvec.sv
// Bench for hh_output_gate_matvec: behavioural memories, integer dot-product
// reference, handshake/address monitor and directed run sequence.
module tb_hh_output_gate_matvec;
  import bilstm_pkg::*;

  localparam int HS  = 128;
  localparam int WPR = 64;
  localparam int ROW_LAT = WPR + 4;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  logic   start;
  logic   busy, done;
  state_t dbg_state;

  always #5 clk = ~clk;

  hh_output_gate_matvec_if bus ();

  hh_output_gate_matvec dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- memories and reference ----------------
  shortint     w_mat [HS][HS];
  shortint     h_vec [HS];
  logic [31:0] w_mem [HS*WPR];
  logic [31:0] h_mem [WPR];
  logic [15:0] exp_q [$];

  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_rd_data <= w_mem[bus.w_rd_addr];
    if (bus.h_rd_en) bus.h_rd_data <= h_mem[bus.h_rd_addr];
  end

  // ---------------- monitor ----------------
  int          cyc = 0;
  logic        mon_clear = 1'b0;
  logic [12:0] exp_w;
  logic [5:0]  exp_h;
  int          en_cnt, addr_err, done_cnt, done_cyc;
  logic [15:0] got_data_q [$];
  logic [6:0]  got_row_q [$];
  int          en_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_clear) begin
      exp_w    <= '0;
      exp_h    <= '0;
      en_cnt   <= 0;
      addr_err <= 0;
      done_cnt <= 0;
      done_cyc <= 0;
      got_data_q.delete();
      got_row_q.delete();
      en_q.delete();
    end else if (!rst) begin
      if (bus.w_rd_en !== bus.h_rd_en) addr_err <= addr_err + 1;
      if (bus.w_rd_en === 1'b1) begin
        if (bus.w_rd_addr !== exp_w || bus.h_rd_addr !== exp_h) addr_err <= addr_err + 1;
        exp_w  <= exp_w + 1'b1;
        exp_h  <= exp_h + 1'b1;
        en_cnt <= en_cnt + 1;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        got_data_q.push_back(bus.out_data);
        got_row_q.push_back(bus.out_row);
        en_q.push_back(en_cnt);
        en_cnt <= 0;
      end
      if (done === 1'b1) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0 identity, 1 all max, 2 min weights, 3 random + row-5 floor case, 4 random
  task automatic load_pattern(input int mode);
    int tmp;
    longint acc;
    for (int c = 0; c < HS; c++) begin
      case (mode)
        0:       h_vec[c] = shortint'(c * 256);
        1, 2:    h_vec[c] = 16'sh7FFF;
        default: begin
          tmp = int'($urandom_range(0, 1023)) - 512;
          h_vec[c] = shortint'(tmp);
        end
      endcase
    end
    for (int r = 0; r < HS; r++) begin
      for (int c = 0; c < HS; c++) begin
        case (mode)
          0:       w_mat[r][c] = (r == c) ? 16'sh0100 : 16'sh0000;
          1:       w_mat[r][c] = 16'sh7FFF;
          2:       w_mat[r][c] = 16'sh8000;
          default: begin
            tmp = int'($urandom_range(0, 1023)) - 512;
            w_mat[r][c] = shortint'(tmp);
          end
        endcase
      end
    end
    if (mode == 3) begin
      for (int c = 0; c < HS; c++) w_mat[5][c] = 16'sh0000;
      w_mat[5][0] = 16'shFF80;
      h_vec[0]    = 16'sh0001;
    end
    for (int r = 0; r < HS; r++)
      for (int k = 0; k < WPR; k++)
        w_mem[r*WPR + k] = {w_mat[r][2*k+1], w_mat[r][2*k]};
    for (int k = 0; k < WPR; k++)
      h_mem[k] = {h_vec[2*k+1], h_vec[2*k]};
    // Reference: exact integer dot product, floor divide by 256, clamp
    exp_q.delete();
    for (int r = 0; r < HS; r++) begin
      acc = 0;
      for (int c = 0; c < HS; c++) acc += longint'(w_mat[r][c]) * longint'(h_vec[c]);
      acc = acc >>> 8;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      exp_q.push_back(acc[15:0]);
    end
  endtask

  task automatic clear_monitor();
    mon_clear = 1'b1;
    tick();
    mon_clear = 1'b0;
  endtask

  // Full mat-vec with optional back-pressure on one row and a stray start
  task automatic run_full(input int bp_row, input bit restart_mid);
    int  start_cyc;
    int  lat_exp;
    int  n_out;
    bit  bp_done;
    bp_done = 1'b0;
    lat_exp = HS * ROW_LAT + ((bp_row >= 0) ? 10 : 0);
    clear_monitor();
    start_cyc = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("state_issue", dbg_state, ISSUE);
    check("first_w_en", bus.w_rd_en, 1);
    for (int i = 0; i < 12000; i++) begin
      if (done_cnt != 0) break;
      start = (restart_mid && i == 1000);
      if (bp_row >= 0 && !bp_done && bus.out_valid && bus.out_row == 7'(bp_row)) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          tick();
          check("bp_valid", bus.out_valid, 1);
          check("bp_data", bus.out_data, exp_q[bp_row]);
          check("bp_row", bus.out_row, bp_row);
          check("bp_no_read", bus.w_rd_en | bus.h_rd_en, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_valid_drop", bus.out_valid, 0);
        check("bp_next_issue", bus.w_rd_en, 1);
        check("bp_next_addr", bus.w_rd_addr, (bp_row + 1) * WPR);
        bp_done = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    repeat (5) tick();
    if (bp_row >= 0) check("bp_seen", bp_done, 1);
    check("done_count", done_cnt, 1);
    check("busy_after_done", busy, 0);
    check("state_after_done", dbg_state, IDLE);
    check("latency", done_cyc - start_cyc - 1, lat_exp);
    check("rows_out", got_data_q.size(), HS);
    check("addr_errors", addr_err, 0);
    n_out = (got_data_q.size() < HS) ? got_data_q.size() : HS;
    for (int r = 0; r < n_out; r++) begin
      check($sformatf("row%0d_index", r), got_row_q[r], r);
      check($sformatf("row%0d_data", r), got_data_q[r], exp_q[r]);
      check($sformatf("row%0d_reads", r), en_q[r], WPR);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_w_en"}, bus.w_rd_en, 0);
    check({pfx, "_h_en"}, bus.h_rd_en, 0);
    check({pfx, "_w_addr"}, bus.w_rd_addr, 0);
    check({pfx, "_h_addr"}, bus.h_rd_addr, 0);
    check({pfx, "_out_valid"}, bus.out_valid, 0);
    check({pfx, "_out_row"}, bus.out_row, 0);
    check({pfx, "_out_data"}, bus.out_data, 0);
    check({pfx, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit found;
    rst = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Identity weights: row r yields h[r]
    load_pattern(0);
    run_full(-1, 1'b0);

    // Positive and negative saturation
    load_pattern(1);
    run_full(-1, 1'b0);
    check("sat_pos_row0", got_data_q[0], 16'h7FFF);
    load_pattern(2);
    run_full(-1, 1'b0);
    check("sat_neg_row0", got_data_q[0], 16'h8000);

    // Random data, floor case on row 5, stall on row 3, stray start mid-run
    load_pattern(3);
    run_full(3, 1'b1);
    check("floor_row5", got_data_q[5], 16'hFFFF);

    // Abort during row 7 issue, with start coinciding with reset
    load_pattern(4);
    clear_monitor();
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.w_rd_en && bus.w_rd_addr == 13'(7*WPR + 10)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("row7_reached", found, 1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (5) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", dbg_state, IDLE);
    check("abort_not_busy", busy, 0);

    // Fresh start after the abort
    run_full(-1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hh_output_gate_matvec.md
Name: hh_output_gate_matvec

Overview:
- Downstream consumer of the hidden-to-hidden output-gate weight memory.
- Sequences burst reads of the 32-bit packed weight words (two signed 16-bit weights per word) and, in lockstep, reads the previous hidden state h(t-1) from the hidden-state buffer.
- Computes the W_hh·h(t-1) dot product one row at a time.
- Emits each row's saturated 16-bit fixed-point result over a valid/ready handshake to the output-gate adder/activation stage.

Parameters:
- DATA_WIDTH, 16, width of one weight / hidden element (signed fixed point).
- FRAC_BITS, 8, fractional bits of the Q format (Q7.8).
- HIDDEN_SIZE, 128, rows = columns of W_hh; must be even.
- ADDR_WIDTH, 13, weight-word address width (HIDDEN_SIZE*HIDDEN_SIZE/2 words).
- H_ADDR_WIDTH, 6, hidden-buffer word address width (HIDDEN_SIZE/2 words).
- ACC_WIDTH, 40, accumulator width.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse to begin a full mat-vec; ignored unless idle
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last row is accepted downstream
- w_rd_en  out  1  weight memory read_enable
- w_rd_addr  out  ADDR_WIDTH  weight word address (row*HIDDEN_SIZE/2 + k)
- w_rd_data  in  2*DATA_WIDTH  weight word, valid 1 cycle after w_rd_en
- h_rd_en  out  1  hidden buffer read enable
- h_rd_addr  out  H_ADDR_WIDTH  hidden word address k
- h_rd_data  in  2*DATA_WIDTH  hidden word, valid 1 cycle after h_rd_en
- out_valid  out  1  row result valid
- out_ready  in  1  downstream accepts result
- out_row  out  clog2(HIDDEN_SIZE)  row index of current result
- out_data  out  DATA_WIDTH  saturated signed row result

Behaviour:
- Word packing, both memories: bits [15:0] = column 2k, bits [31:16] = column 2k+1. Both halves are signed.
- Reset: state IDLE; busy=0, done=0, w_rd_en=0, h_rd_en=0, addresses=0, out_valid=0, out_row=0, out_data=0; accumulator and pipeline valid bits cleared.
- Reset mid-operation aborts the operation immediately with no done pulse. In-flight memory returns are discarded.
- FSM states: IDLE, ISSUE, DRAIN, PRESENT.
- IDLE:
  - On start, go to ISSUE with row=0, k=0, accumulator=0, busy=1.
- ISSUE:
  - Each cycle assert w_rd_en and h_rd_en with w_rd_addr = row*(HIDDEN_SIZE/2)+k and h_rd_addr = k; k increments.
  - After k = HIDDEN_SIZE/2-1 is issued, go to DRAIN.
  - One row takes exactly HIDDEN_SIZE/2 issue cycles (64 by default).
- Pipeline, per issued word:
  - Stage 1: memory data arrives.
  - Stage 2: register two signed 32-bit products, w_lo*h_lo and w_hi*h_hi.
  - Stage 3: accumulator += sign-extended (p_lo + p_hi).
  - The stage valid bits track the enables.
- DRAIN:
  - Wait until all 64 words have been accumulated (3 cycles after the last issue).
  - Then form the result, load out_data and out_row, assert out_valid, go to PRESENT.
- Result formation: arithmetic right shift of the accumulator by FRAC_BITS (truncation toward −inf), then saturate to [−32768, 32767].
- PRESENT:
  - out_valid, out_data and out_row are held stable until out_ready=1.
  - On handshake: out_valid=0 next cycle and the accumulator is cleared.
  - If row was HIDDEN_SIZE-1: pulse done, busy=0, go to IDLE.
  - Otherwise: row+1, k=0, go to ISSUE.
- If out_ready is already high when out_valid rises, the handshake completes in that first PRESENT cycle.
- Memories are never read outside ISSUE; addresses hold their last value when the enables are low.
- start while busy is ignored. start in the same cycle as rst is ignored because reset wins.
- Rows are strictly sequential; there is no overlap between rows. Back-pressure only stalls PRESENT.
- Minimum total latency with out_ready held high: HIDDEN_SIZE*(HIDDEN_SIZE/2 + 4) cycles from start to done.

Decomposition:
- Shared package (bilstm_pkg):
  - Q-format constants: DATA_WIDTH, FRAC_BITS, SAT_MAX, SAT_MIN.
  - HIDDEN_SIZE and derived WORDS_PER_ROW.
  - FSM state encoding typedef.
- One natural sub-module, dual_mac_sat: two-lane multiply, sum, accumulate with clear, plus the shift/saturate output function. Reused later by the input-hidden gates.

Test Plan:
- Identity W (1.0 = 0x0100 on the diagonal), h[i]=i<<8, out_ready=1 -> out_data row r = r<<8, rows 0..127 in order, done once, start-to-done = 128*68 cycles.
- All weights 0x7FFF, all h 0x7FFF -> every row saturates to 0x7FFF; all weights 0x8000 with h 0x7FFF -> every row 0x8000.
- Row 5 has w=0xFF80 (−0.5) in column 0 only, h[0]=0x0001 -> product −128 >> 8 = −1, so out_data=0xFFFF (floor, not zero).
- out_ready held low 10 cycles on row 3 -> out_valid, out_data and out_row stable throughout, no memory reads issued, row 4 issue begins the cycle after the handshake.
- start pulsed again mid-run -> ignored, results unchanged; rst asserted during ISSUE of row 7 -> all outputs reach their reset values next cycle, no done; a fresh start produces row 0 correctly.
- Address check: w_rd_addr sequence 0..8191 contiguous and h_rd_addr cycling 0..63 per row, enables high exactly 64 cycles per row.
